// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch control with redirect flush and halt.
// Redirects load the target and hold fetch off for FLUSH_CYCLES cycles while flush_po squashes the wrong path.
module fetch_pc_unit #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                clk_pi,
    input  logic                reset_pi,
    input  logic                stall_pi,
    input  logic                is_branch_taken_pi,
    input  logic [PC_WIDTH-1:0] branch_target_pi,
    input  logic                jump_pi,
    input  logic [PC_WIDTH-1:0] jump_target_pi,
    input  logic                halt_pi,
    output logic [PC_WIDTH-1:0] pc_po,
    output logic [PC_WIDTH-1:0] pc_plus1_po,
    output logic                fetch_valid_po,
    output logic                flush_po,
    output logic                halted_po
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic                redirect;
    logic [PC_WIDTH-1:0] target;

    assign redirect = is_branch_taken_pi | jump_pi;
    assign target   = is_branch_taken_pi ? branch_target_pi : jump_target_pi;

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state <= RUN;
            pc    <= RESET_PC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // HALT keeps everything frozen; only reset leaves it
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = FLUSH;
                    cnt_nxt   = FC;
                end else if (halt_pi) begin
                    state_nxt = HALT;
                end else if (!stall_pi) begin
                    pc_nxt = pc + 1'b1;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pc_nxt  = target;
                    cnt_nxt = FC;
                end else begin
                    cnt_nxt   = cnt - 3'd1;
                    state_nxt = (cnt == 3'd1) ? RUN : FLUSH;
                end
            end
            HALT: ;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_po          = pc;
        pc_plus1_po    = pc + 1'b1;
        fetch_valid_po = (state == RUN) & ~stall_pi;
        flush_po       = (state == FLUSH);
        halted_po      = (state == HALT);
    end
endmodule
